// File: rtl/aes_round_sequencer_pkg.sv
// Shared types for the AES round sequencer: FSM encoding and block width.
package aes_ctrl_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        RESP  = 2'd2
    } aes_fsm_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Request, response and round-datapath signals of the AES round sequencer.
interface aes_round_sequencer_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned DATA_W     = aes_ctrl_pkg::AES_BLOCK_W
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned RND_W = $clog2(NUM_ROUNDS + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_pt;
    logic [NUM_REQ*DATA_W-1:0] req_key;
    logic                      abort;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;
    logic [DATA_W-1:0]         dp_state_o;
    logic [DATA_W-1:0]         dp_key_o;
    logic [RND_W-1:0]          dp_round;
    logic                      dp_final;
    logic [DATA_W-1:0]         dp_state_i;
    logic [DATA_W-1:0]         dp_key_i;

    modport slave (
        input  req_valid, req_pt, req_key, abort, rsp_ready, dp_state_i, dp_key_i,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy,
               dp_state_o, dp_key_o, dp_round, dp_final
    );

    modport master (
        output req_valid, req_pt, req_key, abort, rsp_ready, dp_state_i, dp_key_i,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy,
               dp_state_o, dp_key_o, dp_round, dp_final
    );

endinterface

// File: rtl/aes_round_sequencer_rr_arbiter.sv
// Round-robin pick: first asserted request scanning upward from last_grant+1.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [ID_W-1:0]    o_idx_c,
    output logic               o_any_c
);

    logic [ID_W-1:0] w_cand;
    logic            w_found;

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = ID_W'((int'(i_last_grant) + k) % int'(NUM_REQ));
            if (!w_found && i_req[w_cand]) begin
                w_found           = 1'b1;
                o_idx_c           = w_cand;
                o_grant_c[w_cand] = 1'b1;
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Shares one single-round AES datapath between requesters: arbitrate, add the
// initial round key, iterate NUM_ROUNDS rounds, return the tagged ciphertext.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned DATA_W     = AES_BLOCK_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_sequencer_if.slave  io_bus
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned RND_W = $clog2(NUM_ROUNDS + 1);

    aes_fsm_e            r_fsm,        w_fsm_nxt;
    logic [DATA_W-1:0]   r_state,      w_state_nxt;
    logic [DATA_W-1:0]   r_rkey,       w_rkey_nxt;
    logic [RND_W-1:0]    r_round,      w_round_nxt;
    logic [ID_W-1:0]     r_id,         w_id_nxt;
    logic [ID_W-1:0]     r_last_grant, w_last_nxt;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_gnt_any;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [DATA_W-1:0]   w_sel_pt;
    logic [DATA_W-1:0]   w_sel_key;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req        (io_bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_gnt),
        .o_idx_c      (w_gnt_idx),
        .o_any_c      (w_gnt_any)
    );

    // Plaintext/key of the winning requester.
    always_comb begin
        w_sel_pt  = '0;
        w_sel_key = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_pt  = io_bus.req_pt[i*DATA_W +: DATA_W];
                w_sel_key = io_bus.req_key[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_rkey_nxt  = r_rkey;
        w_round_nxt = r_round;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last_grant;
        w_req_ready = '0;
        case (r_fsm)
            IDLE: begin
                if (!io_bus.abort && w_gnt_any) begin
                    w_req_ready = w_gnt;
                    w_state_nxt = w_sel_pt ^ w_sel_key;
                    w_rkey_nxt  = w_sel_key;
                    w_round_nxt = RND_W'(1);
                    w_id_nxt    = w_gnt_idx;
                    w_last_nxt  = w_gnt_idx;
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                if (io_bus.abort) begin
                    w_state_nxt = '0;
                    w_rkey_nxt  = '0;
                    w_round_nxt = '0;
                    w_fsm_nxt   = IDLE;
                end else begin
                    w_state_nxt = io_bus.dp_state_i;
                    w_rkey_nxt  = io_bus.dp_key_i;
                    if (r_round == RND_W'(NUM_ROUNDS)) begin
                        w_round_nxt = '0;
                        w_fsm_nxt   = RESP;
                    end else begin
                        w_round_nxt = r_round + RND_W'(1);
                    end
                end
            end
            RESP: begin
                // Abort wins over a coincident handshake; both leave no key material behind.
                if (io_bus.abort || io_bus.rsp_ready) begin
                    w_state_nxt = '0;
                    w_rkey_nxt  = '0;
                    w_round_nxt = '0;
                    w_fsm_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = '0;
                w_rkey_nxt  = '0;
                w_round_nxt = '0;
                w_fsm_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= IDLE;
            r_state      <= '0;
            r_rkey       <= '0;
            r_round      <= '0;
            r_id         <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_state      <= w_state_nxt;
            r_rkey       <= w_rkey_nxt;
            r_round      <= w_round_nxt;
            r_id         <= w_id_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // Intermediate state only leaves through the datapath port while in ROUND.
    assign io_bus.req_ready  = rst_n ? w_req_ready : '0;
    assign io_bus.busy       = (r_fsm != IDLE);
    assign io_bus.rsp_valid  = (r_fsm == RESP);
    assign io_bus.rsp_data   = (r_fsm == RESP)  ? r_state : '0;
    assign io_bus.rsp_id     = (r_fsm == RESP)  ? r_id    : '0;
    assign io_bus.dp_state_o = (r_fsm == ROUND) ? r_state : '0;
    assign io_bus.dp_key_o   = (r_fsm == ROUND) ? r_rkey  : '0;
    assign io_bus.dp_round   = (r_fsm == ROUND) ? r_round : '0;
    assign io_bus.dp_final   = (r_fsm == ROUND) && (r_round == RND_W'(NUM_ROUNDS));

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer with an XOR/increment datapath stub.
module tb_aes_round_sequencer;
    import aes_ctrl_pkg::*;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned DATA_W     = 128;
    localparam logic [127:0] PT1_X  = 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
    localparam logic [127:0] KEY1_X = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_last;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.NUM_REQ(NUM_REQ), .NUM_ROUNDS(NUM_ROUNDS), .DATA_W(DATA_W)) bus ();

    aes_round_sequencer #(.NUM_REQ(NUM_REQ), .NUM_ROUNDS(NUM_ROUNDS), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always_comb begin
        bus.dp_state_i = bus.dp_state_o ^ {16{4'h0, bus.dp_round}};
        bus.dp_key_i   = bus.dp_key_o + 128'd1;
    end

    typedef struct {
        logic [1:0]   mask;
        logic [127:0] pt;
        logic [127:0] key;
        int           delay;
        int           exp_id;
    } vec_t;

    vec_t vecs [6];

    // State entering round n+1: initial whitening then n round constants folded in.
    function automatic logic [127:0] mstate(input logic [127:0] pt, input logic [127:0] key, input int n);
        logic [127:0] s;
        s = pt ^ key;
        for (int r = 1; r <= n; r++) s = s ^ {16{4'h0, 4'(r)}};
        return s;
    endfunction

    function automatic int rr_pick(input logic [1:0] mask, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (mask[(last + k) % 2]) return (last + k) % 2;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [1:0] mask, input logic [127:0] pt, input logic [127:0] key,
                          input int delay, input int exp_id);
        logic [127:0] e_pt, e_key, e_ct;
        logic [1:0]   e_gnt;
        bit           granted;
        e_pt  = (exp_id == 1) ? (pt ^ PT1_X) : pt;
        e_key = (exp_id == 1) ? (key ^ KEY1_X) : key;
        e_ct  = mstate(e_pt, e_key, NUM_ROUNDS);
        e_gnt = 2'b01 << exp_id;
        chk("idle_busy", bus.busy, 0);
        chk("idle_dp_state", bus.dp_state_o, 0);
        bus.req_pt    = {pt ^ PT1_X, pt};
        bus.req_key   = {key ^ KEY1_X, key};
        bus.req_valid = mask;
        granted = 0;
        for (int w = 0; w < 4 && !granted; w++) begin
            #1;
            if (bus.req_ready != 0) granted = 1;
            else cyc();
        end
        if (!granted) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: got req_ready=0 expected %b", e_gnt);
            bus.req_valid = '0;
            return;
        end
        chk("grant", bus.req_ready, e_gnt);
        m_last = exp_id;
        cyc();
        bus.req_valid[exp_id] = 1'b0;
        for (int r = 1; r <= int'(NUM_ROUNDS); r++) begin
            #1;
            chk("dp_round", bus.dp_round, r);
            chk("dp_final", bus.dp_final, (r == int'(NUM_ROUNDS)));
            chk("dp_state_o", bus.dp_state_o, mstate(e_pt, e_key, r - 1));
            chk("dp_key_o", bus.dp_key_o, e_key + 128'(r - 1));
            chk("round_req_ready", bus.req_ready, 0);
            chk("round_rsp_valid", bus.rsp_valid, 0);
            cyc();
        end
        for (int d = 0; d <= delay; d++) begin
            #1;
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_data", bus.rsp_data, e_ct);
            chk("rsp_id", bus.rsp_id, exp_id);
            chk("resp_req_ready", bus.req_ready, 0);
            chk("resp_dp_state", bus.dp_state_o, 0);
            chk("resp_dp_round", bus.dp_round, 0);
            if (d == delay) bus.rsp_ready = 1'b1;
            cyc();
        end
        bus.rsp_ready = 1'b0;
        #1;
        chk("post_busy", bus.busy, 0);
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_rsp_data", bus.rsp_data, 0);
    endtask

    initial begin
        logic [127:0] rpt, rkey;
        logic [1:0]   rmask;
        bit           saw_rsp;

        vecs[0] = '{2'b11, 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100, 128'h1, 0, 1};
        vecs[1] = '{2'b11, 128'h0,                                       128'h0, 5, 0};
        vecs[2] = '{2'b10, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 2, 1};
        vecs[3] = '{2'b10, 128'h1234,                                    128'h5678, 0, 1};
        vecs[4] = '{2'b01, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h7fff, 1, 0};
        vecs[5] = '{2'b11, 128'hcafe,                                    128'hf00d, 0, 1};

        bus.req_valid = 2'b11;
        bus.req_pt    = '0;
        bus.req_key   = '0;
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b0;
        m_last        = 1;

        repeat (3) cyc();
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_dp_state", bus.dp_state_o, 0);
        chk("rst_dp_round", bus.dp_round, 0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        cyc();

        do_txn(2'b01, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff,
               128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f, 0, 0);

        for (int i = 0; i < 6; i++)
            do_txn(vecs[i].mask, vecs[i].pt, vecs[i].key, vecs[i].delay, vecs[i].exp_id);

        // Abort at round 4.
        bus.req_pt    = {128'h0, 128'h77};
        bus.req_key   = {128'h0, 128'h99};
        bus.req_valid = 2'b01;
        #1;
        chk("abort_grant", bus.req_ready, 2'b01);
        m_last = 0;
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        #1;
        chk("abort_round", bus.dp_round, 4);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_dp_state", bus.dp_state_o, 0);
        chk("abort_dp_key", bus.dp_key_o, 0);
        chk("abort_dp_round", bus.dp_round, 0);
        saw_rsp = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.rsp_valid) saw_rsp = 1;
            cyc();
        end
        chk("abort_no_rsp", saw_rsp, 0);

        // Abort coincident with a would-be grant.
        bus.req_valid = 2'b11;
        bus.abort     = 1'b1;
        #1;
        chk("abort_blocks_grant", bus.req_ready, 0);
        cyc();
        bus.abort = 1'b0;
        chk("abort_blocks_busy", bus.busy, 0);
        do_txn(2'b11, 128'h4242, 128'h2424, 0, rr_pick(2'b11, m_last));

        // Abort in RESP together with rsp_ready.
        bus.req_valid = 2'b01;
        #1;
        chk("abort_resp_grant", bus.req_ready, 2'b01);
        m_last = 0;
        cyc();
        bus.req_valid = '0;
        repeat (NUM_ROUNDS) cyc();
        #1;
        chk("abort_resp_valid", bus.rsp_valid, 1);
        bus.abort     = 1'b1;
        bus.rsp_ready = 1'b1;
        cyc();
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("abort_resp_busy", bus.busy, 0);
        chk("abort_resp_rsp", bus.rsp_valid, 0);

        // Asynchronous reset at round 7 after a req0 grant.
        bus.req_valid = 2'b01;
        #1;
        chk("rst7_grant", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        repeat (6) cyc();
        #1;
        chk("rst7_round", bus.dp_round, 7);
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rst7_busy", bus.busy, 0);
        chk("rst7_dp_state", bus.dp_state_o, 0);
        chk("rst7_dp_key", bus.dp_key_o, 0);
        chk("rst7_dp_round", bus.dp_round, 0);
        chk("rst7_dp_final", bus.dp_final, 0);
        chk("rst7_rsp_valid", bus.rsp_valid, 0);
        chk("rst7_rsp_data", bus.rsp_data, 0);
        chk("rst7_req_ready", bus.req_ready, 0);
        cyc();
        rst_n  = 1'b1;
        m_last = 1;
        do_txn(2'b11, 128'h1111, 128'h2222, 0, 0);
        do_txn(2'b11, 128'h3333, 128'h4444, 0, 1);

        for (int i = 0; i < 30; i++) begin
            rmask = 2'($urandom_range(1, 3));
            rpt   = {$urandom, $urandom, $urandom, $urandom};
            rkey  = {$urandom, $urandom, $urandom, $urandom};
            do_txn(rmask, rpt, rkey, $urandom_range(0, 3), rr_pick(rmask, m_last));
        end
        bus.req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
